// File: rtl/enclave_pkg.sv
// Shared constants, FSM state encoding and byte-merge helper for the
// LWE enclave host interface.
package enclave_pkg;

  localparam logic [31:0] DEF_OPCODE_ADDR = 32'h3000_0000;
  localparam logic [31:0] DEF_DATA_BASE   = 32'h3000_1000;
  localparam logic [31:0] DEF_OUTPUT_ADDR = 32'h3000_8000;
  localparam int unsigned DEF_DATA_WIDTH  = 128;
  localparam int unsigned DEF_ADDR_WIDTH  = 10;

  localparam int unsigned STAT_BUSY_BIT = 0;
  localparam int unsigned STAT_ERR_BIT  = 1;

  typedef enum logic [7:0] {
    OPC_NOP     = 8'h00,
    OPC_KEYGEN  = 8'h01,
    OPC_ENCRYPT = 8'h02,
    OPC_DECRYPT = 8'h03
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_ACK
  } state_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [3:0]  sel,
                                             input logic [31:0] new_w);
    logic [31:0] r;
    r = old_w;
    for (int unsigned b = 0; b < 4; b++) begin
      if (sel[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_lane_buffer.sv
// LANES x 32-bit byte-enabled register file; merged_o is the buffer with the
// current write already applied, so the top can commit it in the same cycle.
module wb_lane_buffer
  import enclave_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned LB    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [LB-1:0]         lane_i,
  input  logic [3:0]            sel_i,
  input  logic [31:0]           dat_i,
  output logic [LANES*32-1:0]   merged_o
);

  logic [LANES*32-1:0] lanes_q;

  always_comb begin
    merged_o = lanes_q;
    if (we_i) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        if (lane_i == LB'(l))
          merged_o[l*32 +: 32] = byte_merge(lanes_q[l*32 +: 32], sel_i, dat_i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    lanes_q <= '0;
    else if (we_i) lanes_q <= merged_o;
  end

endmodule

// File: rtl/wb_sram_bridge.sv
// Wishbone slave front end for the LWE enclave: packs host writes into SRAM
// words, returns 32-bit lanes on reads, and launches opcodes into the core.
module wb_sram_bridge
  import enclave_pkg::*;
#(
  parameter logic [31:0] OPCODE_ADDR = DEF_OPCODE_ADDR,
  parameter logic [31:0] DATA_BASE   = DEF_DATA_BASE,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_dat_i,
  input  logic [31:0]           wbs_adr_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  sram_wen_o,
  output logic                  sram_ren_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i,
  output logic [31:0]           opcode_o,
  output logic                  op_valid_o,
  input  logic                  core_busy_i
);

  localparam int unsigned LANES     = DATA_WIDTH / 32;
  localparam int unsigned LB        = $clog2(LANES);
  localparam logic [31:0] WIN_BYTES = 32'((64'd1 << ADDR_WIDTH) * (DATA_WIDTH / 8));

  state_e              state_q, state_d;
  logic [31:0]         dat_q, dat_d;
  logic [31:0]         opcode_q, opcode_d;
  logic                op_valid_q, op_valid_d;
  logic                err_q, err_d;
  logic [LB-1:0]       lane_q, lane_d;

  logic                req, hit_data, hit_opc, hit_stat, buf_we;
  logic [31:0]         off, stat_word, rd_lane;
  logic [LB-1:0]       lane;
  logic [ADDR_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] merged;

  // Decode on the offset from DATA_BASE: one unsigned compare covers both
  // window bounds, and word/lane index the window rather than the absolute address.
  assign off      = wbs_adr_i - DATA_BASE;
  assign hit_data = (off < WIN_BYTES);
  assign lane     = off[LB+1:2];
  assign word     = off[ADDR_WIDTH+LB+1:LB+2];
  assign hit_opc  = (wbs_adr_i == OPCODE_ADDR);
  assign hit_stat = (wbs_adr_i == OPCODE_ADDR + 32'd4);
  assign req      = wbs_stb_i & wbs_cyc_i & rst_n;

  always_comb begin
    stat_word                = '0;
    stat_word[STAT_ERR_BIT]  = err_q;
    stat_word[STAT_BUSY_BIT] = core_busy_i;
  end

  wb_lane_buffer #(.LANES(LANES), .LB(LB)) u_lane_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (buf_we),
    .lane_i   (lane),
    .sel_i    (wbs_sel_i),
    .dat_i    (wbs_dat_i),
    .merged_o (merged)
  );

  always_comb begin
    state_d      = state_q;
    dat_d        = dat_q;
    opcode_d     = opcode_q;
    op_valid_d   = 1'b0;
    err_d        = err_q;
    lane_d       = lane_q;
    buf_we       = 1'b0;
    sram_wen_o   = 1'b0;
    sram_ren_o   = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    rd_lane      = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (lane_q == LB'(l)) rd_lane = sram_rdata_i[l*32 +: 32];
    end

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (hit_data) begin
            if (!core_busy_i) begin
              if (wbs_we_i) begin
                buf_we  = 1'b1;
                state_d = ST_ACK;
                if (lane == LB'(LANES - 1)) begin
                  sram_wen_o   = 1'b1;
                  sram_addr_o  = word;
                  sram_wdata_o = merged;
                end
              end else begin
                sram_ren_o  = 1'b1;
                sram_addr_o = word;
                lane_d      = lane;
                state_d     = ST_RD_WAIT;
              end
            end
          end else begin
            state_d = ST_ACK;
            if (hit_opc) begin
              if (!wbs_we_i)         dat_d = opcode_q;
              else if (core_busy_i)  err_d = 1'b1;
              else begin
                opcode_d   = byte_merge(opcode_q, wbs_sel_i, wbs_dat_i);
                op_valid_d = 1'b1;
              end
            end else if (hit_stat) begin
              if (!wbs_we_i) begin
                dat_d = stat_word;
                err_d = 1'b0;
              end
            end else if (!wbs_we_i) begin
              dat_d = '0;
            end
          end
        end
      end
      ST_RD_WAIT: begin
        dat_d   = rd_lane;
        state_d = ST_ACK;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      dat_q      <= '0;
      opcode_q   <= '0;
      op_valid_q <= 1'b0;
      err_q      <= 1'b0;
      lane_q     <= '0;
    end else begin
      state_q    <= state_d;
      dat_q      <= dat_d;
      opcode_q   <= opcode_d;
      op_valid_q <= op_valid_d;
      err_q      <= err_d;
      lane_q     <= lane_d;
    end
  end

  assign wbs_ack_o  = (state_q == ST_ACK);
  assign wbs_dat_o  = dat_q;
  assign opcode_o   = opcode_q;
  assign op_valid_o = op_valid_q;

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Directed plus randomized bench for wb_sram_bridge against a behavioural
// model of the lane buffer, SRAM contents, opcode and error flag.
module tb_wb_sram_bridge;

  localparam logic [31:0] BASE = 32'h3000_1000;
  localparam logic [31:0] OPC  = 32'h3000_0000;
  localparam logic [31:0] STAT = 32'h3000_0004;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wb_stb, wb_cyc, wb_we;
  logic [3:0]   wb_sel;
  logic [31:0]  wb_dat, wb_adr;
  logic         ack;
  logic [31:0]  dat_o;
  logic         wen, ren;
  logic [9:0]   saddr;
  logic [127:0] wdata, rdata;
  logic [31:0]  opcode;
  logic         opv;
  logic         busy;

  always #5 clk = ~clk;

  wb_sram_bridge #(
    .OPCODE_ADDR (OPC),
    .DATA_BASE   (BASE),
    .DATA_WIDTH  (128),
    .ADDR_WIDTH  (10)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wbs_stb_i    (wb_stb),
    .wbs_cyc_i    (wb_cyc),
    .wbs_we_i     (wb_we),
    .wbs_sel_i    (wb_sel),
    .wbs_dat_i    (wb_dat),
    .wbs_adr_i    (wb_adr),
    .wbs_ack_o    (ack),
    .wbs_dat_o    (dat_o),
    .sram_wen_o   (wen),
    .sram_ren_o   (ren),
    .sram_addr_o  (saddr),
    .sram_wdata_o (wdata),
    .sram_rdata_i (rdata),
    .opcode_o     (opcode),
    .op_valid_o   (opv),
    .core_busy_i  (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Environment: SRAM storage and event monitors
  logic [127:0] sram [0:1023];
  int           wen_cnt = 0, ack_cnt = 0, opv_cnt = 0;
  logic [9:0]   last_waddr = '0;
  logic [127:0] last_wdata = '0;

  always @(posedge clk) begin
    if (wen) begin
      sram[saddr] <= wdata;
      wen_cnt     <= wen_cnt + 1;
      last_waddr  <= saddr;
      last_wdata  <= wdata;
    end
    if (ren) rdata <= sram[saddr];
    if (ack) ack_cnt <= ack_cnt + 1;
    if (opv) opv_cnt <= opv_cnt + 1;
  end

  // Reference model
  logic [31:0]  mbuf [4];
  logic [127:0] mmem [int];
  logic [31:0]  mop;
  logic         merr;

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [3:0] s,
                                         input logic [31:0] d);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (d & m);
  endfunction

  function automatic logic [127:0] mword(input int w);
    return mmem.exists(w) ? mmem[w] : 128'h0;
  endfunction

  function automatic logic [31:0] daddr(input int w, input int l);
    return BASE + 32'(w * 16 + l * 4);
  endfunction

  task automatic m_wr(input int w, input int l, input logic [3:0] s, input logic [31:0] d);
    mbuf[l] = bmerge(mbuf[l], s, d);
    if (l == 3) mmem[w] = {mbuf[3], mbuf[2], mbuf[1], mbuf[0]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wb(input string tag, input logic we, input logic [31:0] a, input logic [3:0] s,
                    input logic [31:0] d, output logic [31:0] rd, output int lat);
    logic got;
    got = 1'b0;
    lat = -1;
    rd  = '0;
    @(posedge clk); #1;
    wb_stb = 1'b1; wb_cyc = 1'b1; wb_we = we; wb_adr = a; wb_sel = s; wb_dat = d;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ack) begin
        got = 1'b1;
        lat = n - 1;
        rd  = dat_o;
        break;
      end
    end
    chk({tag, "_ack"}, 128'(got), 128'd1);
    @(posedge clk); #1;
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
  endtask

  logic [31:0]  rd, d, expw;
  logic [127:0] tmpw;
  logic [3:0]   s;
  int           lat, w, l, kind, w0, a0, o0;
  logic         got;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) sram[i] = '0;
    for (int i = 0; i < 4; i++) mbuf[i] = '0;
    mop = '0; merr = 1'b0; rdata = '0;
    rst_n = 1'b0; busy = 1'b0;
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0; wb_sel = '0; wb_dat = '0; wb_adr = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 128'(ack), 128'd0);
    chk("rst_dat", 128'(dat_o), 128'd0);
    chk("rst_strobes", 128'({wen, ren}), 128'd0);
    chk("rst_addr", 128'(saddr), 128'd0);
    chk("rst_wdata", wdata, 128'd0);
    chk("rst_opcode", 128'({opcode, opv}), 128'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: four lane writes commit one word
    w0 = wen_cnt;
    for (int i = 0; i < 4; i++) begin
      d = {8{4'(i + 1)}};
      wb("t1_wr", 1'b1, daddr(2, i), 4'hF, d, rd, lat);
      m_wr(2, i, 4'hF, d);
      chk("t1_lat", 128'(lat), 128'd1);
    end
    chk("t1_wen_cnt", 128'(wen_cnt - w0), 128'd1);
    chk("t1_waddr", 128'(last_waddr), 128'd2);
    chk("t1_wdata", last_wdata, 128'h44444444_33333333_22222222_11111111);

    // 2: data read latency and lane select
    wb("t2_rd", 1'b0, BASE + 32'h28, 4'hF, '0, rd, lat);
    chk("t2_lat", 128'(lat), 128'd2);
    chk("t2_dat", 128'(rd), 128'h33333333);

    // 3: opcode launch, busy rejection, status and err clear
    o0 = opv_cnt;
    wb("t3_op", 1'b1, OPC, 4'hF, 32'hA5, rd, lat);
    mop = bmerge(mop, 4'hF, 32'hA5);
    chk("t3_opcode", 128'(opcode), 128'hA5);
    chk("t3_pulse", 128'(opv_cnt - o0), 128'd1);
    wb("t3_oprd", 1'b0, OPC, 4'hF, '0, rd, lat);
    chk("t3_oprd", 128'(rd), 128'(mop));
    busy = 1'b1;
    o0 = opv_cnt;
    wb("t3_opbusy", 1'b1, OPC, 4'hF, 32'h77, rd, lat);
    merr = 1'b1;
    chk("t3_opbusy_keep", 128'(opcode), 128'(mop));
    chk("t3_opbusy_pulse", 128'(opv_cnt - o0), 128'd0);
    wb("t3_st1", 1'b0, STAT, 4'hF, '0, rd, lat);
    chk("t3_st1", 128'(rd), 128'({merr, busy}));
    merr = 1'b0;
    wb("t3_st2", 1'b0, STAT, 4'hF, '0, rd, lat);
    chk("t3_st2", 128'(rd), 128'({merr, busy}));
    busy = 1'b0;
    wb("t3_stwr", 1'b1, STAT, 4'hF, 32'hFFFF_FFFF, rd, lat);
    wb("t3_st3", 1'b0, STAT, 4'hF, '0, rd, lat);
    chk("t3_st3", 128'(rd), 128'd0);

    // 4: data write stalls while the core is busy
    w0 = wen_cnt; a0 = ack_cnt; d = $urandom;
    busy = 1'b1;
    @(posedge clk); #1;
    wb_stb = 1'b1; wb_cyc = 1'b1; wb_we = 1'b1; wb_adr = daddr(7, 3); wb_sel = 4'hF; wb_dat = d;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t4_stall_ack", 128'(ack_cnt - a0), 128'd0);
    chk("t4_stall_wen", 128'(wen_cnt - w0), 128'd0);
    @(posedge clk); #1 busy = 1'b0;
    got = 1'b0; lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ack) begin got = 1'b1; lat = n - 1; break; end
    end
    @(posedge clk); #1;
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
    m_wr(7, 3, 4'hF, d);
    chk("t4_ack", 128'(got), 128'd1);
    chk("t4_lat", 128'(lat), 128'd1);
    chk("t4_wen", 128'(wen_cnt - w0), 128'd1);
    chk("t4_wdata", last_wdata, mword(7));

    // 5: partial byte enables on the committing lane
    wb("t5_clr", 1'b1, daddr(5, 3), 4'hF, 32'h0, rd, lat);
    m_wr(5, 3, 4'hF, 32'h0);
    wb("t5_wr", 1'b1, daddr(5, 3), 4'b0011, 32'hDEADBEEF, rd, lat);
    m_wr(5, 3, 4'b0011, 32'hDEADBEEF);
    tmpw = mword(5);
    chk("t5_lane3", 128'(last_wdata[127:96]), 128'h0000BEEF);
    chk("t5_word", last_wdata, tmpw);

    // Randomized mix checked against the model
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 3);
      w = $urandom_range(0, 15);
      l = $urandom_range(0, 3);
      s = 4'($urandom);
      d = $urandom;
      case (kind)
        0, 1: begin
          w0 = wen_cnt;
          wb("rnd_wr", 1'b1, daddr(w, l) + 32'($urandom_range(0, 3)), s, d, rd, lat);
          m_wr(w, l, s, d);
          chk("rnd_wr_lat", 128'(lat), 128'd1);
          chk("rnd_wr_wen", 128'(wen_cnt - w0), 128'(l == 3));
          if (l == 3) begin
            chk("rnd_wr_addr", 128'(last_waddr), 128'(w));
            chk("rnd_wr_data", last_wdata, mword(w));
          end
        end
        2: begin
          wb("rnd_rd", 1'b0, daddr(w, l), 4'hF, '0, rd, lat);
          tmpw = mword(w);
          expw = tmpw[l*32 +: 32];
          chk("rnd_rd_lat", 128'(lat), 128'd2);
          chk("rnd_rd_dat", 128'(rd), 128'(expw));
        end
        default: begin
          o0 = opv_cnt;
          wb("rnd_op", 1'b1, OPC, s, d, rd, lat);
          mop = bmerge(mop, s, d);
          chk("rnd_op_val", 128'(opcode), 128'(mop));
          chk("rnd_op_pulse", 128'(opv_cnt - o0), 128'd1);
        end
      endcase
    end

    // 6: unmapped read, then reset during RD_WAIT
    wb("t6_unmap", 1'b0, 32'h2000_0000, 4'hF, '0, rd, lat);
    chk("t6_unmap_dat", 128'(rd), 128'd0);
    chk("t6_unmap_lat", 128'(lat), 128'd1);
    wb("t6_prime", 1'b0, BASE + 32'h28, 4'hF, '0, rd, lat);
    a0 = ack_cnt;
    @(posedge clk); #1;
    wb_stb = 1'b1; wb_cyc = 1'b1; wb_we = 1'b0; wb_adr = BASE + 32'h28; wb_sel = 4'hF;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rst_ack", 128'(ack), 128'd0);
    chk("t6_rst_dat", 128'(dat_o), 128'd0);
    chk("t6_rst_strobes", 128'({wen, ren}), 128'd0);
    chk("t6_rst_addr", 128'(saddr), 128'd0);
    chk("t6_rst_wdata", wdata, 128'd0);
    chk("t6_rst_opcode", 128'({opcode, opv}), 128'd0);
    wb_stb = 1'b0; wb_cyc = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) mbuf[i] = '0;
    mop = '0; merr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t6_no_ack", 128'(ack_cnt - a0), 128'd0);
    d = $urandom;
    wb("t6_post", 1'b1, daddr(9, 3), 4'hF, d, rd, lat);
    m_wr(9, 3, 4'hF, d);
    chk("t6_buf_cleared", last_wdata, mword(9));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
